// File: rtl/qspi_rom_reader.sv
// qspi_rom_reader: byte-read front end for a quad-SPI serial ROM (mode 0, sclk idles low).
// A byte request opens a stream with command 0xEB, a 24-bit address and dummy cycles,
// then reads one byte as two nibbles. The stream stays selected in HOLD so that a
// request for the next consecutive address skips straight to the data phase.
//
// Ports:
//   clk, rst_n            system clock, async active-low reset
//   req_valid/req_addr/req_ready   byte read request handshake
//   flush                 close an open stream (honoured in HOLD only)
//   rsp_valid/rsp_data    one-cycle response pulse, data held until the next response
//   qspi_sclk/qspi_cs_n   flash clock and chip select
//   qspi_io_out/qspi_io_oe  command/address nibbles and their output enable
//   qspi_io_in            data nibbles from the flash
module qspi_rom_reader #(
  parameter int          SCLK_HALF      = 1,
  parameter logic [7:0]  CMD_BYTE       = 8'hEB,
  parameter int          DUMMY_CYCLES   = 6,
  parameter int          CS_HIGH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic [23:0] req_addr,
  output logic        req_ready,
  input  logic        flush,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        qspi_sclk,
  output logic        qspi_cs_n,
  output logic [3:0]  qspi_io_out,
  output logic        qspi_io_oe,
  input  logic [3:0]  qspi_io_in
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, HOLD, DESEL} state_e;

  state_e      state_q;
  logic [3:0]  hcnt_q;      // clk cycles into the current sclk half-period
  logic [7:0]  bcnt_q;      // per-phase counter (bits, nibbles, dummy rises, deselect cycles)
  logic [23:0] sh_q;        // outgoing command/address shift register
  logic [23:0] next_addr_q; // address of the byte the open stream will return next
  logic [7:0]  byte_q;
  logic        done_q;      // both data nibbles captured, response goes out next cycle
  logic        restart_q;   // DESEL was entered for a non-sequential request
  logic        sclk_q, cs_n_q, oe_q, rsp_valid_q;
  logic [3:0]  io_out_q;
  logic [7:0]  rsp_data_q;

  logic tick, rise, fall, run;

  // rise/fall mark the clk edge on which sclk_q toggles to 1 / to 0.
  assign tick = (hcnt_q == 4'(SCLK_HALF - 1));
  assign rise = tick && !sclk_q;
  assign fall = tick &&  sclk_q;
  assign run  = (state_q == CMD) || (state_q == ADDR) || (state_q == DUMMY) ||
                ((state_q == DATA) && !done_q);

  assign req_ready   = rst_n && !flush && ((state_q == IDLE) || (state_q == HOLD));
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign qspi_sclk   = sclk_q;
  assign qspi_cs_n   = cs_n_q;
  assign qspi_io_out = io_out_q;
  assign qspi_io_oe  = oe_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      hcnt_q      <= '0;
      bcnt_q      <= '0;
      sh_q        <= '0;
      next_addr_q <= '0;
      byte_q      <= '0;
      done_q      <= 1'b0;
      restart_q   <= 1'b0;
      sclk_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      oe_q        <= 1'b0;
      io_out_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= 1'b0;

      // sclk generator; phase logic below may override on entry into a state
      if (run) begin
        hcnt_q <= tick ? 4'd0 : hcnt_q + 4'd1;
        if (tick) sclk_q <= ~sclk_q;
      end

      case (state_q)
        IDLE: begin
          if (req_valid && req_ready) begin
            next_addr_q <= req_addr;
            cs_n_q      <= 1'b0;
            oe_q        <= 1'b1;
            io_out_q    <= {3'b000, CMD_BYTE[7]};
            sh_q        <= {CMD_BYTE[6:0], 17'h0};
            sclk_q      <= 1'b0;
            hcnt_q      <= '0;
            bcnt_q      <= '0;
            state_q     <= CMD;
          end
        end

        // Outputs advance on rising edges; the flash samples the value held
        // through the preceding low half.
        CMD: begin
          if (rise) begin
            if (bcnt_q == 8'd7) begin
              io_out_q <= next_addr_q[23:20];
              sh_q     <= {next_addr_q[19:0], 4'h0};
              bcnt_q   <= '0;
              state_q  <= ADDR;
            end else begin
              io_out_q <= {3'b000, sh_q[23]};
              sh_q     <= {sh_q[22:0], 1'b0};
              bcnt_q   <= bcnt_q + 8'd1;
            end
          end
        end

        ADDR: begin
          if (rise) begin
            if (bcnt_q == 8'd5) begin
              io_out_q <= '0;
              oe_q     <= 1'b0;
              bcnt_q   <= '0;
              state_q  <= DUMMY;
            end else begin
              io_out_q <= sh_q[23:20];
              sh_q     <= {sh_q[19:0], 4'h0};
              bcnt_q   <= bcnt_q + 8'd1;
            end
          end
        end

        // Leave on the falling edge after the last dummy rise so DATA always
        // starts with sclk low, exactly like a sequential hit from HOLD.
        DUMMY: begin
          if (rise) begin
            bcnt_q <= bcnt_q + 8'd1;
          end else if (fall && (bcnt_q == 8'(DUMMY_CYCLES))) begin
            bcnt_q  <= '0;
            state_q <= DATA;
          end
        end

        // Flash holds a nibble stable from its rising edge, so it is captured
        // at the end of the sclk-high half.
        DATA: begin
          if (done_q) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= byte_q;
            next_addr_q <= next_addr_q + 24'd1;
            done_q      <= 1'b0;
            state_q     <= HOLD;
          end else if (fall) begin
            if (bcnt_q == 8'd0) begin
              byte_q[7:4] <= qspi_io_in;
              bcnt_q      <= 8'd1;
            end else begin
              byte_q[3:0] <= qspi_io_in;
              bcnt_q      <= '0;
              done_q      <= 1'b1;
            end
          end
        end

        HOLD: begin
          if (flush) begin
            cs_n_q    <= 1'b1;
            bcnt_q    <= '0;
            restart_q <= 1'b0;
            state_q   <= DESEL;
          end else if (req_valid) begin
            if (req_addr == next_addr_q) begin
              hcnt_q  <= '0;
              bcnt_q  <= '0;
              state_q <= DATA;
            end else begin
              next_addr_q <= req_addr;
              cs_n_q      <= 1'b1;
              bcnt_q      <= '0;
              restart_q   <= 1'b1;
              state_q     <= DESEL;
            end
          end
        end

        DESEL: begin
          if (bcnt_q == 8'(CS_HIGH_CYCLES - 1)) begin
            bcnt_q <= '0;
            if (restart_q) begin
              cs_n_q   <= 1'b0;
              oe_q     <= 1'b1;
              io_out_q <= {3'b000, CMD_BYTE[7]};
              sh_q     <= {CMD_BYTE[6:0], 17'h0};
              sclk_q   <= 1'b0;
              hcnt_q   <= '0;
              state_q  <= CMD;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            bcnt_q <= bcnt_q + 8'd1;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
